// File: rtl/chip8_pkg.sv
// Shared constants and arbiter state encoding for the CHIP-8 VRAM slice.
// CHIP8_VRAM_CLEAR_EN adds the CLEAR arbiter state.
package chip8_pkg;

  localparam int VRAM_ROWS = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DISP  = 2'd1,
    ST_CPU   = 2'd2
`ifdef CHIP8_VRAM_CLEAR_EN
    , ST_CLEAR = 2'd3
`endif
  } arb_state_e;

endpackage

// File: rtl/chip8_vram_clear.sv
// Clear engine: walks rows 0..VRAM_ROWS-1 writing zeros whenever the arbiter grants it.
// Only instantiated when CHIP8_VRAM_CLEAR_EN is defined.
module chip8_vram_clear #(
  parameter int ROW_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_req,
  input  logic             clear_gnt,
  output logic             clear_busy,
  output logic             clear_want,
  output logic [ROW_W-1:0] clear_row
);
  import chip8_pkg::*;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(VRAM_ROWS - 1);

  logic             busy_r;
  logic             fin_r;
  logic [ROW_W-1:0] row_r;

  // Busy flag, row counter and the one-cycle tail after the last row is written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      fin_r  <= 1'b0;
      row_r  <= {ROW_W{1'b0}};
    end else if (!busy_r) begin
      busy_r <= clear_req;
    end else if (fin_r) begin
      busy_r <= 1'b0;
      fin_r  <= 1'b0;
    end else if (clear_gnt) begin
      fin_r  <= (row_r == LAST_ROW);
      row_r  <= (row_r == LAST_ROW) ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
    end else begin
      row_r  <= row_r;
    end
  end

  assign clear_busy = busy_r;
  assign clear_want = busy_r & ~fin_r;
  assign clear_row  = row_r;

endmodule

// File: rtl/chip8_vram_arbiter.sv
// Single-port VRAM arbiter between the CPU, the display scanout and an optional clear engine.
// Define CHIP8_VRAM_CLEAR_EN to build in the clear engine.
module chip8_vram_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  import chip8_pkg::*;

  localparam int                   STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_r;
  arb_state_e          next_s;
  logic [STARVE_W-1:0] starve_r;
  logic                starved_s;
  logic                cpu_ok_s;
  logic                clr_block_s;
  logic                cpu_pend_r;
  logic                disp_pend_r;

`ifdef CHIP8_VRAM_CLEAR_EN
  logic                clr_want_s;
  logic                clr_gnt_s;
  logic [ADDR_W-1:0]   clr_row_s;

  assign clr_gnt_s = (next_s == ST_CLEAR);

  chip8_vram_clear #(
    .ROW_W (ADDR_W)
  ) u_clear (
    .clock      (clock),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_gnt  (clr_gnt_s),
    .clear_busy (clear_busy),
    .clear_want (clr_want_s),
    .clear_row  (clr_row_s)
  );

  // The CPU is held off from the cycle a clear is requested until the clear engine is idle again.
  assign clr_block_s = clear_busy | clear_req;
`else
  logic unused_clear_s;
  assign unused_clear_s = clear_req;
  assign clear_busy     = 1'b0;
  assign clr_block_s    = 1'b0;
`endif

  assign starved_s = (starve_r == STARVE_MAX);
  assign cpu_ok_s  = cpu_req & ~clr_block_s;

  // Per-cycle winner: starved CPU, then scanout, then clear engine, then CPU.
  always_comb begin
    next_s = ST_IDLE;
    if (starved_s && cpu_ok_s) begin
      next_s = ST_CPU;
    end else if (disp_req) begin
      next_s = ST_DISP;
`ifdef CHIP8_VRAM_CLEAR_EN
    end else if (clr_want_s) begin
      next_s = ST_CLEAR;
`endif
    end else if (cpu_ok_s) begin
      next_s = ST_CPU;
    end else begin
      next_s = ST_IDLE;
    end
  end

  // Arbiter FSM: grants, VRAM command and starve counter all launch on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      starve_r  <= {STARVE_W{1'b0}};
      cpu_gnt   <= 1'b0;
      disp_gnt  <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      mem_write <= 1'b0;
    end else begin
      state_r  <= next_s;
      cpu_gnt  <= (next_s == ST_CPU);
      disp_gnt <= (next_s == ST_DISP);

      if (!cpu_req || (next_s == ST_CPU)) begin
        starve_r <= {STARVE_W{1'b0}};
      end else if (!starved_s) begin
        starve_r <= starve_r + STARVE_W'(1);
      end else begin
        starve_r <= starve_r;
      end

      // Idle cycles keep the last address and data on the bus.
      case (next_s)
        ST_CPU: begin
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
          mem_write <= cpu_write;
        end
        ST_DISP: begin
          mem_addr  <= disp_addr;
          mem_write <= 1'b0;
        end
`ifdef CHIP8_VRAM_CLEAR_EN
        ST_CLEAR: begin
          mem_addr  <= clr_row_s;
          mem_wdata <= {DATA_W{1'b0}};
          mem_write <= 1'b1;
        end
`endif
        default: begin
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Read return pipe: VRAM answers one cycle after the command, captured one cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_pend_r  <= 1'b0;
      disp_pend_r <= 1'b0;
      cpu_rvalid  <= 1'b0;
      disp_rvalid <= 1'b0;
      cpu_rdata   <= {DATA_W{1'b0}};
      disp_rdata  <= {DATA_W{1'b0}};
    end else begin
      cpu_pend_r  <= (state_r == ST_CPU) && !mem_write;
      disp_pend_r <= (state_r == ST_DISP);
      cpu_rvalid  <= cpu_pend_r;
      disp_rvalid <= disp_pend_r;
      if (cpu_pend_r) begin
        cpu_rdata <= mem_rdata;
      end else begin
        cpu_rdata <= cpu_rdata;
      end
      if (disp_pend_r) begin
        disp_rdata <= mem_rdata;
      end else begin
        disp_rdata <= disp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_chip8_vram_arbiter.sv
// Directed self-checking bench for chip8_vram_arbiter with a synchronous VRAM model.
// The clear-engine scenario is compiled in when CHIP8_VRAM_CLEAR_EN is defined.
module tb_chip8_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_write = 1'b0;
  logic [4:0]  cpu_addr = 5'd0;
  logic [63:0] cpu_wdata = 64'd0;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [63:0] cpu_rdata;
  logic        disp_req = 1'b0;
  logic [4:0]  disp_addr = 5'd0;
  logic        disp_gnt;
  logic        disp_rvalid;
  logic [63:0] disp_rdata;
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic [4:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic [63:0] mem_rdata;

  logic [63:0] vram [32];
  int          n_pass = 0;
  int          n_total = 0;

  chip8_vram_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_gnt    (disp_gnt),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .clear_req   (clear_req),
    .clear_busy  (clear_busy),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_write   (mem_write),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous VRAM; a few rows are preloaded while reset is held.
  always @(posedge clock) begin
    if (!reset) begin
      vram[3]   <= 64'hF0;
      vram[5]   <= 64'h55AA;
      vram[7]   <= 64'h7777;
      vram[31]  <= 64'hDEAD;
      mem_rdata <= 64'd0;
    end else begin
      if (mem_write) vram[mem_addr] <= mem_wdata;
      mem_rdata <= vram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_gnt"},    {63'd0, cpu_gnt},     64'd0);
    check({tag, "_disp_gnt"},   {63'd0, disp_gnt},    64'd0);
    check({tag, "_mem_write"},  {63'd0, mem_write},   64'd0);
    check({tag, "_mem_addr"},   {59'd0, mem_addr},    64'd0);
    check({tag, "_mem_wdata"},  mem_wdata,            64'd0);
    check({tag, "_cpu_rvalid"}, {63'd0, cpu_rvalid},  64'd0);
    check({tag, "_cpu_rdata"},  cpu_rdata,            64'd0);
    check({tag, "_disp_rvalid"},{63'd0, disp_rvalid}, 64'd0);
    check({tag, "_disp_rdata"}, disp_rdata,           64'd0);
    check({tag, "_clear_busy"}, {63'd0, clear_busy},  64'd0);
  endtask

  initial begin
    logic [9:0]  exp_disp;
    logic [63:0] others;
    int          busy_cnt;
    bit          seen;

    // Reset state
    tick();
    tick();
    check_all_zero("rst");
    reset = 1'b1;

    // CPU read of row 3 directly after reset release
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 5'd3;
    tick();
    check("rd3_gnt",   {63'd0, cpu_gnt},   64'd1);
    check("rd3_addr",  {59'd0, mem_addr},  64'd3);
    check("rd3_wr",    {63'd0, mem_write}, 64'd0);
    cpu_req = 1'b0;
    tick();
    check("rd3_rv_t1", {63'd0, cpu_rvalid}, 64'd0);
    tick();
    check("rd3_rv_t2", {63'd0, cpu_rvalid}, 64'd1);
    check("rd3_data",  cpu_rdata,           64'hF0);
    tick();
    check("rd3_rv_t3", {63'd0, cpu_rvalid}, 64'd0);

    // Write row 31 then read it back-to-back
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 5'd31; cpu_wdata = 64'h1;
    tick();
    check("wr31_gnt",   {63'd0, cpu_gnt},   64'd1);
    check("wr31_wr",    {63'd0, mem_write}, 64'd1);
    check("wr31_addr",  {59'd0, mem_addr},  64'd31);
    check("wr31_wdata", mem_wdata,          64'h1);
    cpu_write = 1'b0;
    tick();
    check("rd31_gnt", {63'd0, cpu_gnt},   64'd1);
    check("rd31_wr",  {63'd0, mem_write}, 64'd0);
    cpu_req = 1'b0;
    tick();
    check("wr31_no_rvalid", {63'd0, cpu_rvalid}, 64'd0);
    tick();
    check("rd31_rvalid", {63'd0, cpu_rvalid}, 64'd1);
    check("rd31_data",   cpu_rdata,           64'h1);

    // Scanout and CPU contending: four scanout grants, then the starved CPU
    exp_disp = 10'b0111101111;
    disp_req = 1'b1; disp_addr = 5'd5;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 5'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("arb_disp_%0d", i), {63'd0, disp_gnt}, {63'd0, exp_disp[i]});
      check($sformatf("arb_cpu_%0d", i),  {63'd0, cpu_gnt},  {63'd0, ~exp_disp[i]});
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    tick();
    check("arb_disp_rvalid", {63'd0, disp_rvalid}, 64'd1);
    check("arb_disp_rdata",  disp_rdata,           64'h55AA);
    check("arb_cpu_rv_early",{63'd0, cpu_rvalid},  64'd0);
    tick();
    check("arb_cpu_rvalid",  {63'd0, cpu_rvalid},  64'd1);
    check("arb_cpu_rdata",   cpu_rdata,            64'h7777);
    check("idle_hold_addr",  {59'd0, mem_addr},    64'd7);
    check("idle_no_write",   {63'd0, mem_write},   64'd0);
    check("idle_no_gnt",     {62'd0, cpu_gnt, disp_gnt}, 64'd0);

`ifdef CHIP8_VRAM_CLEAR_EN
    // Clear requested together with a CPU write: the clear runs first
    clear_req = 1'b1;
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 5'd10; cpu_wdata = 64'hAB;
    tick();
    clear_req = 1'b0;
    check("clr_busy_set", {63'd0, clear_busy}, 64'd1);
    check("clr_cpu_wait", {63'd0, cpu_gnt},    64'd0);
    busy_cnt = 1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (clear_busy) busy_cnt++;
      if (cpu_gnt) begin
        seen = 1'b1;
        check("clr_cpu_after_busy", {63'd0, clear_busy}, 64'd0);
      end
    end
    check("clr_cpu_granted", {63'd0, seen}, 64'd1);
    check("clr_busy_cycles", 64'(busy_cnt), 64'd33);
    cpu_req = 1'b0;
    tick();
    others = 64'd0;
    for (int r = 0; r < 32; r++) begin
      if (r != 10) others = others | vram[r];
    end
    check("clr_rows_zero", others,   64'd0);
    check("clr_row10",     vram[10], 64'hAB);
`else
    // Without the clear engine a clear request has no effect
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("noclr_busy",  {63'd0, clear_busy}, 64'd0);
    check("noclr_write", {63'd0, mem_write},  64'd0);
    tick();
    check("noclr_busy2", {63'd0, clear_busy}, 64'd0);
    check("noclr_write2",{63'd0, mem_write},  64'd0);
`endif

    // Reset one cycle after a CPU read grant discards the response
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 5'd3;
    tick();
    check("rstrd_gnt", {63'd0, cpu_gnt}, 64'd1);
    cpu_req = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    check("rst_no_rvalid", {63'd0, cpu_rvalid}, 64'd0);
    reset = 1'b1;
    tick();
    check("rel_no_rvalid", {63'd0, cpu_rvalid}, 64'd0);

    // First grant possible on the first edge after release
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 5'd3;
    tick();
    check("rel_first_gnt", {63'd0, cpu_gnt}, 64'd1);
    cpu_req = 1'b0;
    tick();
    tick();
    check("rel_rdata", cpu_rdata, 64'hF0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/chip8_vram_arbiter.md
CHIP8_VRAM_ARBITER -- requirements
Module: chip8_vram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  STARVE_LIMIT, 4, consecutive denied CPU cycles before CPU is forced to win
  ADDR_W, 5, VRAM row address width (32 rows)
  DATA_W, 64, VRAM row width in pixels
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning); reset reset, asynchronous, active-low; clock clock:
  clock  in  1  system clock
  reset  in  1  asynchronous active-low reset
  cpu_req  in  1  CPU access request, held until cpu_gnt
  cpu_write  in  1  1=write, 0=read
  cpu_addr  in  ADDR_W  CPU row address
  cpu_wdata  in  DATA_W  CPU write data
  cpu_gnt  out  1  one-cycle grant to CPU
  cpu_rvalid  out  1  one-cycle CPU read data valid
  cpu_rdata  out  DATA_W  CPU read data
  disp_req  in  1  scanout read request, held until disp_gnt
  disp_addr  in  ADDR_W  scanout row address
  disp_gnt  out  1  one-cycle grant to scanout
  disp_rvalid  out  1  one-cycle scanout read data valid
  disp_rdata  out  DATA_W  scanout read data
  clear_req  in  1  one-cycle pulse: zero all rows
  clear_busy  out  1  clear engine active
  mem_addr  out  ADDR_W  VRAM address
  mem_wdata  out  DATA_W  VRAM write data
  mem_write  out  1  VRAM write enable
  mem_rdata  in  DATA_W  VRAM read data, valid one cycle after mem_addr

Function
REQ-003 All outputs SHALL be registered; at most one VRAM access SHALL be issued per cycle; cpu_gnt and disp_gnt SHALL never both be 1.
REQ-004 A grant SHALL be asserted on the same edge that drives mem_addr/mem_write/mem_wdata for that access.
REQ-005 Read data SHALL be registered into x_rdata with x_rvalid=1 exactly 2 cycles after x_gnt; writes SHALL produce no rvalid.
REQ-006 Back-to-back grants to either requester SHALL be allowed every cycle; each requester SHALL see responses in issue order.
REQ-007 Priority per cycle: starved CPU > scanout > clear engine > CPU.
REQ-008 Starve counter SHALL increment each cycle cpu_req=1 without cpu_gnt, clear on cpu_gnt or cpu_req=0, and saturate at STARVE_LIMIT; at STARVE_LIMIT the CPU is starved.
REQ-009 Idle cycles (no grant) SHALL drive mem_write=0; mem_addr/mem_wdata SHALL hold their last values.
REQ-010 FSM states IDLE, DISP, CPU, CLEAR: the state SHALL record the granted source of the current cycle and select next by REQ-007.
REQ-011 clear_req while clear_busy=1 SHALL be ignored; clear_req simultaneous with a CPU write SHALL grant the clear first (CPU waits).

Reset
REQ-012 On reset=0 all outputs SHALL be 0, FSM SHALL enter IDLE, starve counter SHALL be 0, in-flight read responses SHALL be discarded, and any clear SHALL be aborted.
REQ-013 Deassertion SHALL be synchronous to clock; the first grant SHALL be possible on the first edge after release.

Configuration
REQ-014 Macro CHIP8_VRAM_CLEAR_EN: defined -> clear engine present: clear_req sets clear_busy next edge, rows 0..31 written with zeros in ascending order on cycles it wins arbitration, clear_busy drops the edge after row 31 is written, then the row counter wraps to 0.
REQ-015 Without CHIP8_VRAM_CLEAR_EN: clear_req SHALL be ignored, clear_busy SHALL be constant 0, and CLEAR state SHALL be absent.

Structure
REQ-016 Package chip8_pkg SHALL hold VRAM_ROWS=32, ADDR_W, DATA_W, and the arbiter state enum.
REQ-017 The clear engine SHALL be sub-module chip8_vram_clear (row counter, busy flag), instantiated only under CHIP8_VRAM_CLEAR_EN.

Verification
REQ-018 CPU read row 3 alone, VRAM row 3=64'hF0 -> cpu_gnt at T, cpu_rvalid=1, cpu_rdata=64'hF0 at T+2.
REQ-019 disp_req and cpu_req held together for 10 cycles -> disp_gnt on 4 cycles, cpu_gnt on the 5th, pattern repeats; never both grants.
REQ-020 CPU write row 31 with 64'h1 then read row 31 -> mem_write=1 once, and read returns 64'h1 with no rvalid for the write.
REQ-021 With macro: clear_req while the scanout idles -> clear_busy for 32+1 cycles, all rows 0, CPU write issued mid-clear is granted only after clear_busy=0.
REQ-022 Reset asserted 1 cycle after cpu_gnt (read) -> no cpu_rvalid, all outputs 0, clear_busy=0.
